// File: rtl/proc_arbiter.sv
// proc_arbiter: round-robin owner arbitration for a shared 4-phase multiply
// stage. Four requesters compete. The granted owner keeps the stage for one
// whole job: start pulse, wait for busy, run, then a done pulse.
// Optional watchdog: define PROC_WDT_EN to abort stuck WAIT/RUN phases and
// set the sticky err flag. Without it, err is tied low.
module proc_arbiter #(
   parameter int unsigned RUN_MAX = 150
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] req,
   input  logic       busy_proc,
   output logic [3:0] gnt,
   output logic [1:0] sel,
   output logic       data_rdy,
   output logic [3:0] done,
   output logic       busy,
   output logic       err
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT,
      RUN,
      FIN
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] owner_q, owner_d;   // current or last owner; also drives sel
   logic [1:0] ptr_q,   ptr_d;     // last completed owner, lowest priority next
   logic [1:0] rr_pick;
   logic [1:0] rr_idx;
   logic       rr_valid;
   logic [3:0] owner_oh;

`ifdef PROC_WDT_EN
   logic [7:0] wdt_q, wdt_d;
   logic       err_q, err_d;
   logic       wdt_wait_exp;
   logic       wdt_run_exp;

   // The counter is cleared on entry to WAIT and to RUN. It therefore holds
   // (cycles spent in phase - 1). A value of 4 means this is the fifth
   // WAIT cycle. A value of RUN_MAX means RUN_MAX busy cycles have already
   // passed.
   assign wdt_wait_exp = (wdt_q >= 8'd4);
   assign wdt_run_exp  = ({24'd0, wdt_q} >= RUN_MAX);
`endif

   assign owner_oh = 4'b0001 << owner_q;

   // Round-robin pick. Scan offsets 4,3,2,1 from ptr so that the smallest
   // offset (closest above ptr) is written last and wins. Offset 4 is ptr
   // itself, which leaves the previous owner with the lowest priority.
   always_comb begin
      rr_pick  = ptr_q;
      rr_idx   = ptr_q;
      rr_valid = |req;
      for (int unsigned i = 0; i < 4; i++) begin
         rr_idx = ptr_q + 2'(4 - i);
         if (req[rr_idx]) begin
            rr_pick = rr_idx;
         end
      end
   end

   // Next-state logic: job sequencing, owner capture and pointer update.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
`ifdef PROC_WDT_EN
      wdt_d   = (wdt_q == 8'hFF) ? wdt_q : wdt_q + 8'd1;
      err_d   = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (rr_valid) begin
               owner_d = rr_pick;
               state_d = START;
            end
         end
         START: begin
            state_d = WAIT;
`ifdef PROC_WDT_EN
            wdt_d   = '0;
`endif
         end
         WAIT: begin
            if (busy_proc) begin
               state_d = RUN;
`ifdef PROC_WDT_EN
               wdt_d   = '0;
            end else if (wdt_wait_exp) begin
               state_d = FIN;
               err_d   = 1'b1;
`endif
            end
         end
         RUN: begin
            if (!busy_proc) begin
               state_d = FIN;
`ifdef PROC_WDT_EN
            end else if (wdt_run_exp) begin
               state_d = FIN;
               err_d   = 1'b1;
`endif
            end
         end
         FIN: begin
            ptr_d   = owner_q;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output decode: all outputs come from registered state only.
   always_comb begin
      gnt      = '0;
      done     = '0;
      data_rdy = 1'b0;
      busy     = (state_q != IDLE);
      case (state_q)
         START: begin
            gnt      = owner_oh;
            data_rdy = 1'b1;
         end
         WAIT, RUN: begin
            gnt = owner_oh;
         end
         FIN: begin
            done = owner_oh;
         end
         default: begin
            gnt = '0;
         end
      endcase
   end

   assign sel = owner_q;

`ifdef PROC_WDT_EN
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   // State registers. Reset sets ptr to 3 so that requester 0 wins first.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         owner_q <= '0;
         ptr_q   <= 2'd3;
`ifdef PROC_WDT_EN
         wdt_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
`ifdef PROC_WDT_EN
         wdt_q   <= wdt_d;
         err_q   <= err_d;
`endif
      end
   end

`ifndef SYNTHESIS
   a_gnt_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));
   a_done_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(done));
`endif

endmodule
